// File: rtl/obi_mem_responder.sv
// OBI responder serving one core port from a word array; optional grant stall via OBI_RESP_GNT_STALL_EN.
// Responses emerge exactly RD_LATENCY cycles after grant with no backpressure; grant throttled by outstanding count.
module obi_mem_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h0220_0000,
  parameter int          MEM_WORDS       = 4096,
  parameter int          RD_LATENCY      = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
`ifdef OBI_RESP_GNT_STALL_EN
  ,
  input  logic        stall_i
`endif
);

  localparam int          AW   = $clog2(MEM_WORDS);
  localparam int          CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

  logic [31:0]   mem_q [MEM_WORDS];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pipe_vld_q [RD_LATENCY];
  logic          pipe_err_q [RD_LATENCY];
  logic [31:0]   pipe_dat_q [RD_LATENCY];

  logic [32:0]   off;
  logic          in_range;
  logic          xfer;
  logic [AW-1:0] widx;
  logic          st0_vld_d;
  logic          st0_err_d;
  logic [31:0]   st0_dat_d;

  // 33-bit offset: bit 32 set means the address lies below BASE_ADDR, and nothing wraps near 2^32.
  assign off      = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign in_range = !off[32] && (off < SPAN);
  assign widx     = off[AW+1:2];

  // cnt_q still counts a response leaving this cycle, so that slot is only reusable next cycle.
  always_comb begin
    gnt_o = req_i && (cnt_q < CW'(MAX_OUTSTANDING));
`ifdef OBI_RESP_GNT_STALL_EN
    if (stall_i) gnt_o = 1'b0;
`endif
  end

  assign xfer = req_i && gnt_o;

  always_comb begin
    cnt_d = cnt_q;
    if (xfer && !rvalid_o) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!xfer && rvalid_o) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_comb begin
    st0_vld_d = xfer;
    st0_err_d = xfer && !in_range;
    st0_dat_d = '0;
    if (xfer && in_range && !we_i) st0_dat_d = mem_q[widx];
  end

  // The array is deliberately not reset so its contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (rst_ni && xfer && in_range && we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem_q[widx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_err_q[i] <= 1'b0;
        pipe_dat_q[i] <= '0;
      end
    end else begin
      cnt_q         <= cnt_d;
      pipe_vld_q[0] <= st0_vld_d;
      pipe_err_q[0] <= st0_err_d;
      pipe_dat_q[0] <= st0_dat_d;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_err_q[i] <= pipe_err_q[i-1];
        pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
    end
  end

  assign rvalid_o = pipe_vld_q[RD_LATENCY-1];
  assign err_o    = pipe_err_q[RD_LATENCY-1];
  assign rdata_o  = pipe_dat_q[RD_LATENCY-1];

endmodule
